// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with match pulse and saturating counter
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_0111,
  parameter int DEFAULT_LEN = 3,
  parameter bit DEFAULT_OVERLAP = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         x,
  input  logic                         x_valid,
  input  logic                         cnt_clr,
  output logic                         z,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cnt_sat,
  output logic                         busy
);
  localparam int LW = $clog2(MAX_LEN+1);
  typedef enum logic [1:0] {IDLE, FILL, DETECT} state_t;
  state_t state;
  logic [MAX_LEN-1:0] pat, hist, hist_n, mask;
  logic [LW-1:0] len, fill, fill_n, len_c;
  logic ovl, match;
  always_comb begin
    hist_n = {hist[MAX_LEN-2:0], x};
    fill_n = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
    mask = ~({MAX_LEN{1'b1}} << len);
    match = en && x_valid && state != IDLE && fill_n >= len && ((hist_n ^ pat) & mask) == '0;
    len_c = (cfg_len == '0) ? LW'(1) : (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
  end
  assign cnt_sat = &match_cnt;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      hist <= '0;
      fill <= '0;
      z <= 1'b0;
      match_cnt <= '0;
      pat <= DEFAULT_PATTERN;
      len <= LW'(DEFAULT_LEN);
      ovl <= DEFAULT_OVERLAP;
    end else begin
      z <= match;
      match_cnt <= cnt_clr ? (match ? CNT_W'(1) : '0) :
                   (match && !cnt_sat) ? match_cnt + CNT_W'(1) : match_cnt;
      if (state == IDLE && cfg_we) begin
        pat <= cfg_pattern;
        len <= len_c;
        ovl <= cfg_overlap;
      end
      if (!en) begin
        state <= IDLE;
        hist <= '0;
        fill <= '0;
      end else if (state == IDLE) begin
        state <= FILL;
        hist <= '0;
        fill <= '0;
      end else if (x_valid) begin
        hist <= hist_n;
        // without overlap the matching bit starts nothing: refill from scratch
        if (match && !ovl) begin
          state <= FILL;
          fill <= '0;
        end else begin
          fill <= fill_n;
          if (fill_n >= len) state <= DETECT;
        end
      end
    end
endmodule
